regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data word width in bits (WIDTH >= 1).
REQ-002 The block SHALL take parameter DEPTH, default 8, as the number of entries (DEPTH >= 2, power of two not required).
REQ-003 The block SHALL derive AW = max(1, ceil(log2(DEPTH))) internally as the address width; AW is not user-settable.
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, resetn.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 wr  input  1  write request; waddr  input  AW  write address; din  input  WIDTH  write data.
REQ-008 rd0  input  1  port-0 read request; raddr0  input  AW  port-0 address; dout0  output  WIDTH  port-0 data; rvalid0  output  1  port-0 data valid.
REQ-009 rd1  input  1  port-1 read request; raddr1  input  AW  port-1 address; dout1  output  WIDTH  port-1 data; rvalid1  output  1  port-1 data valid.
REQ-010 clr  input  1  synchronous invalidate of all entries.
REQ-011 err  output  1  sticky error flag; err_cause  output  3  sticky causes: [0] uninitialised read, [1] address >= DEPTH, [2] write dropped by clr.
REQ-012 err_clr  input  1  clears sticky error state; err_cnt  output  8  saturating error-event count.

Function
REQ-013 Each entry SHALL have a valid bit; a write with wr=1, waddr<DEPTH, clr=0 SHALL store din at the edge and set that entry valid.
REQ-014 Read latency SHALL be one cycle: rdN=1 sampled at edge k yields doutN/rvalidN registered at edge k, visible until edge k+1.
REQ-015 A successful read (address < DEPTH, entry valid or bypassed, clr=0) SHALL give rvalidN=1 and doutN=entry data.
REQ-016 Any cycle with rdN=0 or a failed read SHALL register doutN=0 and rvalidN=0.
REQ-017 Read and write to the same in-range address in the same cycle SHALL be write-first: doutN=din, rvalidN=1, even if the entry was previously invalid.
REQ-018 Both read ports SHALL operate independently, including same address on both ports and both bypassing simultaneously.
REQ-019 A read of an in-range, invalid, non-bypassed entry SHALL be a failed read and raise cause [0].
REQ-020 A read or write with address >= DEPTH SHALL fail (write dropped, no state change) and raise cause [1], once per offending port.
REQ-021 clr=1 SHALL clear all valid bits at the edge; a concurrent wr=1 SHALL be dropped and raise cause [2]; concurrent reads SHALL return doutN=0, rvalidN=0 and raise no error.
REQ-022 Address-range check SHALL take precedence over clr for cause attribution: out-of-range write during clr raises [1] only.
REQ-023 Memory data SHALL NOT be reset; only valid bits, outputs and error state are reset.
REQ-024 Error events per cycle SHALL be counted per port (0..3); err_cause SHALL OR in new causes; err SHALL equal |err_cause.
REQ-025 err_cnt SHALL add the per-cycle event count and saturate at 255.
REQ-026 err_clr=1 SHALL set err_cause and err_cnt to this cycle's new events only (new events in the err_clr cycle are kept).
REQ-027 rd and wr at the same time SHALL NOT be an error (unlike the single-port predecessor).

Reset
REQ-028 resetn=0 SHALL immediately, without clk, force dout0=dout1=0, rvalid0=rvalid1=0, err=0, err_cause=0, err_cnt=0, all valid bits=0.
REQ-029 While resetn=0, inputs SHALL be ignored; first edge with resetn=1 SHALL operate normally.
REQ-030 Reset asserted mid-write SHALL leave the addressed entry invalid.

Verification
REQ-031 Reset, then idle edge -> all outputs 0, err_cnt=0.
REQ-032 Write 0xA5 to addr 3; next cycle rd0 addr 3, rd1 addr 3 -> dout0=dout1=0xA5, rvalid0=rvalid1=1, err=0.
REQ-033 wr 0x3C addr 5 with rd0 addr 5 same cycle (entry invalid) -> dout0=0x3C, rvalid0=1, err=0; rd1 addr 6 same cycle -> dout1=0, rvalid1=0, err_cause=3'b001, err_cnt=1.
REQ-034 DEPTH=6: wr addr 7 and rd0 addr 6 same cycle -> no write, dout0=0, err_cause[1]=1, err_cnt=2; later rd addr 7 still fails.
REQ-035 Write addr 2, then clr=1 with wr addr 4 -> err_cause[2]=1; next rd0 addr 2 and rd1 addr 4 -> both rvalid=0, cause[0] set, err_cnt +2.
REQ-036 Force 256 uninit reads -> err_cnt=255; err_clr with one failed read same cycle -> err_cnt=1, err=1; async resetn pulse mid-cycle -> outputs 0 before next edge.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with per-entry valid bits, write-first
// bypass, synchronous invalidate, and sticky error reporting with a
// saturating event counter.
module regfile_2r1w #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd0,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] dout0,
  output logic             rvalid0,
  input  logic             rd1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] dout1,
  output logic             rvalid1,
  input  logic             clr,
  output logic             err,
  output logic [2:0]       err_cause,
  input  logic             err_clr,
  output logic [7:0]       err_cnt
);

  // Storage and registered state
  logic [WIDTH-1:0]            mem_q [DEPTH];
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [1:0][WIDTH-1:0]       dout_q, dout_d;
  logic [1:0]                  rvalid_q, rvalid_d;
  logic [2:0]                  err_cause_q, err_cause_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;

  // Per-cycle decode
  logic                        w_in, wr_ok, wr_evt;
  logic [1:0]                  rd_req;
  logic [1:0][AW-1:0]          rd_addr;
  logic [1:0]                  rd_evt;
  logic                        r_in, r_hit;
  logic [2:0]                  new_cause, cause_base;
  logic [1:0]                  evt_num;
  logic [7:0]                  cnt_base;
  logic [8:0]                  cnt_sum;

  // Widen before comparing so non-power-of-two depths are handled uniformly.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Decode write/read requests, bypass, error events and next-state values.
  always_comb begin
    w_in       = in_range(waddr);
    wr_ok      = wr & w_in & ~clr;
    wr_evt     = wr & (~w_in | clr);
    new_cause  = '0;
    if (wr && !w_in) begin
      new_cause[1] = 1'b1;
    end else if (wr && clr) begin
      new_cause[2] = 1'b1;
    end

    rd_req   = {rd1, rd0};
    rd_addr  = {raddr1, raddr0};
    dout_d   = '0;
    rvalid_d = '0;
    rd_evt   = '0;
    r_in     = 1'b0;
    r_hit    = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_in  = in_range(rd_addr[p]);
      r_hit = wr_ok && (waddr == rd_addr[p]);
      if (rd_req[p]) begin
        if (!r_in) begin
          rd_evt[p]    = 1'b1;
          new_cause[1] = 1'b1;
        end else if (!clr) begin
          if (r_hit) begin
            dout_d[p]   = din;
            rvalid_d[p] = 1'b1;
          end else if (valid_q[rd_addr[p]]) begin
            dout_d[p]   = mem_q[rd_addr[p]];
            rvalid_d[p] = 1'b1;
          end else begin
            rd_evt[p]    = 1'b1;
            new_cause[0] = 1'b1;
          end
        end
      end
    end

    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_ok) begin
      valid_d[waddr] = 1'b1;
    end

    evt_num    = 2'(wr_evt) + 2'(rd_evt[0]) + 2'(rd_evt[1]);
    cause_base = err_clr ? 3'b000 : err_cause_q;
    cnt_base   = err_clr ? 8'h00 : err_cnt_q;
    err_cause_d = cause_base | new_cause;
    cnt_sum     = {1'b0, cnt_base} + 9'(evt_num);
    err_cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Data array has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (resetn && wr_ok) begin
      mem_q[waddr] <= din;
    end
  end

  // Valid bits, read outputs and error state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= '0;
      dout_q      <= '0;
      rvalid_q    <= '0;
      err_cause_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      dout_q      <= dout_d;
      rvalid_q    <= rvalid_d;
      err_cause_q <= err_cause_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dout0     = dout_q[0];
  assign dout1     = dout_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign err_cause = err_cause_q;
  assign err       = |err_cause_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w: a DEPTH=8 and a DEPTH=6 instance share one
// stimulus stream; a behavioural model tracks both.
module tb_regfile_2r1w;

  logic       clk;
  logic       resetn;
  logic       wr, rd0, rd1, clr, err_clr;
  logic [2:0] waddr, raddr0, raddr1;
  logic [7:0] din;

  logic [7:0] o_dout0 [2];
  logic [7:0] o_dout1 [2];
  logic       o_rv0 [2];
  logic       o_rv1 [2];
  logic       o_err [2];
  logic [2:0] o_cause [2];
  logic [7:0] o_cnt [2];

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = DEPTH 8, index 1 = DEPTH 6
  int         dep [2] = '{8, 6};
  logic [7:0] m_mem [2][8];
  bit         m_valid [2][8];
  logic [7:0] m_dout0 [2];
  logic [7:0] m_dout1 [2];
  bit         m_rv0 [2];
  bit         m_rv1 [2];
  logic [2:0] m_cause [2];
  int         m_cnt [2];

  regfile_2r1w #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din),
    .rd0(rd0), .raddr0(raddr0), .dout0(o_dout0[0]), .rvalid0(o_rv0[0]),
    .rd1(rd1), .raddr1(raddr1), .dout1(o_dout1[0]), .rvalid1(o_rv1[0]),
    .clr(clr), .err(o_err[0]), .err_cause(o_cause[0]), .err_clr(err_clr),
    .err_cnt(o_cnt[0]));

  regfile_2r1w #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din),
    .rd0(rd0), .raddr0(raddr0), .dout0(o_dout0[1]), .rvalid0(o_rv0[1]),
    .rd1(rd1), .raddr1(raddr1), .dout1(o_dout1[1]), .rvalid1(o_rv1[1]),
    .clr(clr), .err(o_err[1]), .err_cause(o_cause[1]), .err_clr(err_clr),
    .err_cnt(o_cnt[1]));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_valid[k][i] = 0;
      m_dout0[k] = 0; m_dout1[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
      m_cause[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One read port seen from the state before this edge's write.
  task automatic model_read(input int k, input bit r, input int a,
                            output logic [7:0] d, output bit v,
                            inout int evt, inout logic [2:0] nc);
    d = 0; v = 0;
    if (!r) return;
    if (a >= dep[k]) begin evt++; nc[1] = 1; end
    else if (clr) begin end
    else if (wr && waddr == 3'(a)) begin d = din; v = 1; end
    else if (m_valid[k][a]) begin d = m_mem[k][a]; v = 1; end
    else begin evt++; nc[0] = 1; end
  endtask

  task automatic model_step();
    int evt;
    logic [2:0] nc;
    for (int k = 0; k < 2; k++) begin
      evt = 0; nc = 0;
      model_read(k, rd0, int'(raddr0), m_dout0[k], m_rv0[k], evt, nc);
      model_read(k, rd1, int'(raddr1), m_dout1[k], m_rv1[k], evt, nc);
      if (wr) begin
        if (int'(waddr) >= dep[k]) begin evt++; nc[1] = 1; end
        else if (clr) begin evt++; nc[2] = 1; end
        else begin m_mem[k][waddr] = din; m_valid[k][waddr] = 1; end
      end
      if (clr) for (int i = 0; i < 8; i++) m_valid[k][i] = 0;
      if (err_clr) begin m_cause[k] = nc; m_cnt[k] = evt; end
      else begin m_cause[k] = m_cause[k] | nc; m_cnt[k] = m_cnt[k] + evt; end
      if (m_cnt[k] > 255) m_cnt[k] = 255;
    end
  endtask

  task automatic applyIdle();
    wr = 0; rd0 = 0; rd1 = 0; clr = 0; err_clr = 0;
    waddr = 0; raddr0 = 0; raddr1 = 0; din = 0;
  endtask

  // Advance one edge and sample 1ns later; the model follows the same edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (resetn) model_step(); else model_reset();
  endtask

  task automatic do_reset();
    resetn = 0;
    model_reset();
    applyIdle();
    tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    wr = 1; waddr = 1; din = 8'h5A; rd0 = 1; raddr0 = 1; rd1 = 1; raddr1 = 7;
    err_clr = 0; clr = 0;
    resetn = 0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_cnt[k] !== 8'd0 || o_err[k] !== 1'b0 || o_cause[k] !== 3'd0) begin
        failures++;
        $display("FAIL reset_async_err inst=%0d got cnt=%0d err=%b cause=%b exp 0", k, o_cnt[k], o_err[k], o_cause[k]);
      end
    end
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_rv0[k] !== 1'b0 || o_rv1[k] !== 1'b0 || o_dout0[k] !== 8'd0 || o_dout1[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset_held_outputs inst=%0d got rv0=%b rv1=%b d0=%h d1=%h exp 0", k, o_rv0[k], o_rv1[k], o_dout0[k], o_dout1[k]);
      end
    end
    resetn = 1;
    applyIdle();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_rv0[k] !== 1'b0 || o_dout0[k] !== 8'd0 || o_cnt[k] !== 8'd0 || o_err[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_edge inst=%0d got rv0=%b d0=%h cnt=%0d err=%b exp 0", k, o_rv0[k], o_dout0[k], o_cnt[k], o_err[k]);
      end
    end
    rd0 = 1; raddr0 = 1;
    tick();
    applyIdle();
    checks++;
    if (o_rv0[0] !== 1'b0 || o_cause[0] !== 3'b001) begin
      failures++;
      $display("FAIL reset_write_ignored got rv0=%b cause=%b exp rv0=0 cause=001", o_rv0[0], o_cause[0]);
    end
  endtask

  task automatic test_basic_read();
    do_reset();
    wr = 1; waddr = 3; din = 8'hA5;
    tick();
    applyIdle();
    rd0 = 1; raddr0 = 3; rd1 = 1; raddr1 = 3;
    tick();
    applyIdle();
    checks++;
    if (o_dout0[0] !== 8'hA5 || o_dout1[0] !== 8'hA5 || o_rv0[0] !== 1'b1 || o_rv1[0] !== 1'b1 || o_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_read got d0=%h d1=%h rv0=%b rv1=%b err=%b exp A5 A5 1 1 0", o_dout0[0], o_dout1[0], o_rv0[0], o_rv1[0], o_err[0]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    wr = 1; waddr = 5; din = 8'h3C; rd0 = 1; raddr0 = 5; rd1 = 1; raddr1 = 6;
    tick();
    applyIdle();
    checks++;
    if (o_dout0[0] !== 8'h3C || o_rv0[0] !== 1'b1) begin
      failures++;
      $display("FAIL bypass_port0 got d0=%h rv0=%b exp 3C 1", o_dout0[0], o_rv0[0]);
    end
    checks++;
    if (o_dout1[0] !== 8'h00 || o_rv1[0] !== 1'b0 || o_cause[0] !== 3'b001 || o_cnt[0] !== 8'd1) begin
      failures++;
      $display("FAIL bypass_port1_uninit got d1=%h rv1=%b cause=%b cnt=%0d exp 00 0 001 1", o_dout1[0], o_rv1[0], o_cause[0], o_cnt[0]);
    end
    wr = 1; waddr = 4; din = 8'hC7; rd0 = 1; raddr0 = 4; rd1 = 1; raddr1 = 4;
    tick();
    applyIdle();
    checks++;
    if (o_dout0[0] !== 8'hC7 || o_dout1[0] !== 8'hC7 || o_rv0[0] !== 1'b1 || o_rv1[0] !== 1'b1 || o_cnt[0] !== 8'd1) begin
      failures++;
      $display("FAIL bypass_both got d0=%h d1=%h rv0=%b rv1=%b cnt=%0d exp C7 C7 1 1 1", o_dout0[0], o_dout1[0], o_rv0[0], o_rv1[0], o_cnt[0]);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    wr = 1; waddr = 7; din = 8'h11; rd0 = 1; raddr0 = 6;
    tick();
    applyIdle();
    checks++;
    if (o_dout0[1] !== 8'h00 || o_rv0[1] !== 1'b0 || o_cause[1] !== 3'b010 || o_cnt[1] !== 8'd2) begin
      failures++;
      $display("FAIL oor_first got d0=%h rv0=%b cause=%b cnt=%0d exp 00 0 010 2", o_dout0[1], o_rv0[1], o_cause[1], o_cnt[1]);
    end
    rd0 = 1; raddr0 = 7;
    tick();
    applyIdle();
    checks++;
    if (o_rv0[1] !== 1'b0 || o_dout0[1] !== 8'h00 || o_cnt[1] !== 8'd3) begin
      failures++;
      $display("FAIL oor_read_after got rv0=%b d0=%h cnt=%0d exp 0 00 3", o_rv0[1], o_dout0[1], o_cnt[1]);
    end
    wr = 1; waddr = 6; clr = 1;
    tick();
    applyIdle();
    checks++;
    if (o_cause[1] !== 3'b010 || o_cnt[1] !== 8'd4) begin
      failures++;
      $display("FAIL oor_beats_clr got cause=%b cnt=%0d exp 010 4", o_cause[1], o_cnt[1]);
    end
  endtask

  task automatic test_clr();
    do_reset();
    wr = 1; waddr = 2; din = 8'h42;
    tick();
    applyIdle();
    clr = 1; wr = 1; waddr = 4; din = 8'h99; rd0 = 1; raddr0 = 2;
    tick();
    applyIdle();
    checks++;
    if (o_cause[0] !== 3'b100 || o_cnt[0] !== 8'd1 || o_rv0[0] !== 1'b0 || o_dout0[0] !== 8'h00) begin
      failures++;
      $display("FAIL clr_drop_write got cause=%b cnt=%0d rv0=%b d0=%h exp 100 1 0 00", o_cause[0], o_cnt[0], o_rv0[0], o_dout0[0]);
    end
    rd0 = 1; raddr0 = 2; rd1 = 1; raddr1 = 4;
    tick();
    applyIdle();
    checks++;
    if (o_rv0[0] !== 1'b0 || o_rv1[0] !== 1'b0 || o_cause[0] !== 3'b101 || o_cnt[0] !== 8'd3) begin
      failures++;
      $display("FAIL clr_then_read got rv0=%b rv1=%b cause=%b cnt=%0d exp 0 0 101 3", o_rv0[0], o_rv1[0], o_cause[0], o_cnt[0]);
    end
  endtask

  task automatic test_saturate_and_async();
    do_reset();
    wr = 1; waddr = 1; din = 8'h77;
    tick();
    applyIdle();
    rd0 = 1; raddr0 = 0;
    for (int i = 0; i < 256; i++) tick();
    checks++;
    if (o_cnt[0] !== 8'd255) begin
      failures++;
      $display("FAIL saturate got cnt=%0d exp 255", o_cnt[0]);
    end
    err_clr = 1;
    tick();
    applyIdle();
    checks++;
    if (o_cnt[0] !== 8'd1 || o_err[0] !== 1'b1 || o_cause[0] !== 3'b001) begin
      failures++;
      $display("FAIL err_clr_keep_new got cnt=%0d err=%b cause=%b exp 1 1 001", o_cnt[0], o_err[0], o_cause[0]);
    end
    rd1 = 1; raddr1 = 1;
    tick();
    applyIdle();
    checks++;
    if (o_dout1[0] !== 8'h77 || o_rv1[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_async_read got d1=%h rv1=%b exp 77 1", o_dout1[0], o_rv1[0]);
    end
    #3;
    resetn = 0;
    #1;
    checks++;
    if (o_dout1[0] !== 8'h00 || o_rv1[0] !== 1'b0 || o_err[0] !== 1'b0 || o_cnt[0] !== 8'd0 || o_cause[0] !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got d1=%h rv1=%b err=%b cnt=%0d cause=%b exp 0", o_dout1[0], o_rv1[0], o_err[0], o_cnt[0], o_cause[0]);
    end
    resetn = 1;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      wr      = ($urandom_range(0, 1) == 1);
      waddr   = 3'($urandom_range(0, 7));
      din     = 8'($urandom);
      rd0     = ($urandom_range(0, 3) != 0);
      raddr0  = 3'($urandom_range(0, 7));
      rd1     = ($urandom_range(0, 3) != 0);
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 15) == 0);
      err_clr = ($urandom_range(0, 31) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_dout0[k] !== m_dout0[k] || o_rv0[k] !== m_rv0[k]) begin
          failures++;
          $display("FAIL rand_port0 n=%0d inst=%0d got d0=%h rv0=%b exp %h %b", n, k, o_dout0[k], o_rv0[k], m_dout0[k], m_rv0[k]);
        end
        checks++;
        if (o_dout1[k] !== m_dout1[k] || o_rv1[k] !== m_rv1[k]) begin
          failures++;
          $display("FAIL rand_port1 n=%0d inst=%0d got d1=%h rv1=%b exp %h %b", n, k, o_dout1[k], o_rv1[k], m_dout1[k], m_rv1[k]);
        end
        checks++;
        if (o_cause[k] !== m_cause[k] || o_err[k] !== (|m_cause[k]) || o_cnt[k] !== 8'(m_cnt[k])) begin
          failures++;
          $display("FAIL rand_err n=%0d inst=%0d got cause=%b err=%b cnt=%0d exp %b %b %0d", n, k, o_cause[k], o_err[k], o_cnt[k], m_cause[k], |m_cause[k], m_cnt[k]);
        end
      end
    end
    applyIdle();
  endtask

  // Scenario sequence and summary
  initial begin
    resetn = 1;
    applyIdle();
    #2;
    test_reset();
    test_basic_read();
    test_bypass();
    test_out_of_range();
    test_clr();
    test_saturate_and_async();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
